// File: rtl/calc_display_rx.sv
// Digit-stream receiver for the calculator: captures a BCD frame into a
// shadow buffer, commits it atomically and scans it onto an 8-digit display.
module calc_display_rx #(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_done,
    output logic       err
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [3:0]    shadow [8];
    logic [3:0]    disp   [8];
    logic [2:0]    exp_idx;
    logic [CW-1:0] scan_cnt;
    logic [2:0]    scan_idx;

    logic       streaming;
    logic       in_range;
    logic       hit;
    logic       commit;
    logic [7:0] lead;
    logic       blank;
    logic [7:0] next_seg;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'hC0;
            4'd1:    enc = 8'hF9;
            4'd2:    enc = 8'hA4;
            4'd3:    enc = 8'hB0;
            4'd4:    enc = 8'h99;
            4'd5:    enc = 8'h92;
            4'd6:    enc = 8'h82;
            4'd7:    enc = 8'hF8;
            4'd8:    enc = 8'h80;
            4'd9:    enc = 8'h90;
            default: enc = 8'hBF;
        endcase
    endfunction

    assign streaming = (status == 2'b01) && !err;
    assign in_range  = !pos[3];
    assign hit       = (pos[2:0] == exp_idx);
    assign commit    = streaming && in_range && hit && (exp_idx == 3'd7);

    // lead[i] is set when digit i and everything above it are zero
    always_comb begin
        logic run;
        run  = 1'b1;
        lead = '0;
        for (int i = 7; i >= 0; i--) begin
            run     = run && (disp[i] == 4'd0);
            lead[i] = run;
        end
    end

    assign blank = (BLANK_LZ != 0) && (scan_idx != 3'd0) && lead[scan_idx];

    always_comb begin
        next_seg = 8'hFF;
        if (err) begin
            case (scan_idx)
                3'd3:    next_seg = 8'h86;
                3'd2:    next_seg = 8'hAF;
                3'd1:    next_seg = 8'hAF;
                3'd0:    next_seg = 8'hA3;
                default: next_seg = 8'hFF;
            endcase
        end else if (!blank) begin
            next_seg = enc(disp[scan_idx]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err        <= 1'b0;
            frame_done <= 1'b0;
            exp_idx    <= '0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            if (status == 2'b00) err <= 1'b1;
            frame_done <= commit;
            if (!err) begin
                if (status == 2'b01) begin
                    if (in_range) begin
                        if (hit) begin
                            shadow[pos[2:0]] <= data;
                            exp_idx          <= exp_idx + 3'd1;
                        end else if (pos[2:0] == 3'd0) begin
                            shadow[0] <= data;
                            exp_idx   <= 3'd1;
                        end else begin
                            exp_idx <= '0;
                        end
                    end
                end else begin
                    exp_idx <= '0;
                end
            end
            if (commit) begin
                for (int i = 0; i < 7; i++) disp[i] <= shadow[i];
                disp[7] <= data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            an       <= 8'hFF;
            seg      <= 8'hFF;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(8'h01 << scan_idx);
            seg <= next_seg;
        end
    end

endmodule

// File: tb/tb_calc_display_rx.sv
// Bench for calc_display_rx: table of frames with expected scan output,
// plus hand-written abort, error and reset sequences.
module tb_calc_display_rx;

    logic       clock;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an0, seg0, an1, seg1;
    logic       fd0, fd1, err0, err1;

    int checks = 0;
    int failures = 0;
    int sb[$];

    typedef struct {
        logic [31:0] d;
        logic [63:0] e1;
        logic [63:0] e0;
    } vec_t;

    vec_t vt[6];

    calc_display_rx #(.SCAN_DIV(4), .BLANK_LZ(1)) dut0 (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an0), .seg(seg0), .frame_done(fd0), .err(err0)
    );

    calc_display_rx #(.SCAN_DIV(4), .BLANK_LZ(0)) dut1 (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an1), .seg(seg1), .frame_done(fd1), .err(err1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every frame_done pulse must match an expected commit.
    always @(negedge clock) begin
        if (fd0 === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL frame_done_unexpected actual=1 expected=0 t=%0t",
                         $time);
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic [1:0] st, input logic [3:0] p,
                         input logic [3:0] v);
        @(negedge clock);
        status = st;
        pos    = p;
        data   = v;
    endtask

    task automatic send_range(input logic [31:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) drive(2'b01, 4'(i), d[4*i +: 4]);
    endtask

    task automatic finish_frame(input string name, input logic exp);
        if (exp) sb.push_back(1);
        @(negedge clock);
        check({name, "_fd0"}, {63'd0, fd0}, {63'd0, exp});
        check({name, "_fd1"}, {63'd0, fd1}, {63'd0, exp});
        status = 2'b10;
        @(negedge clock);
        check({name, "_fd_off"}, {63'd0, fd0}, 64'd0);
    endtask

    task automatic full_frame(input string name, input logic [31:0] d,
                              input logic exp);
        send_range(d, 0, 7);
        finish_frame(name, exp);
    endtask

    task automatic check_scan(input string name, input logic [63:0] e1,
                              input logic [63:0] e0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want;
            int n;
            want = ~(8'h01 << i);
            n = 0;
            while (an0 !== want && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (n >= 100) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout digit=%0d actual=%h expected=%h",
                         name, i, an0, want);
            end else begin
                check($sformatf("%s_seg_lz1_d%0d", name, i), {56'd0, seg0},
                      {56'd0, e1[8*i +: 8]});
                check($sformatf("%s_seg_lz0_d%0d", name, i), {56'd0, seg1},
                      {56'd0, e0[8*i +: 8]});
                check($sformatf("%s_an1_d%0d", name, i), {56'd0, an1},
                      {56'd0, want});
            end
        end
    endtask

    localparam logic [63:0] ERR_SCR = 64'hFFFFFFFF86AFAFA3;
    localparam logic [63:0] ZERO1   = 64'hFFFFFFFFFFFFFFC0;
    localparam logic [63:0] ZERO0   = 64'hC0C0C0C0C0C0C0C0;

    initial begin
        int n;
        vt[0] = '{32'h00000127, 64'hFFFFFFFFFFF9A4F8, 64'hC0C0C0C0C0F9A4F8};
        vt[1] = '{32'h00000000, ZERO1, ZERO0};
        vt[2] = '{32'h00C00000, 64'hFFFFBFC0C0C0C0C0, 64'hC0C0BFC0C0C0C0C0};
        vt[3] = '{32'h23456789, 64'hA4B0999282F88090, 64'hA4B0999282F88090};
        vt[4] = '{32'h10000000, 64'hF9C0C0C0C0C0C0C0, 64'hF9C0C0C0C0C0C0C0};
        vt[5] = '{32'h000000F0, 64'hFFFFFFFFFFFFBFC0, 64'hC0C0C0C0C0C0BFC0};

        reset  = 1'b1;
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        #1;
        check("reset_an", {56'd0, an0}, 64'hFF);
        check("reset_seg", {56'd0, seg0}, 64'hFF);
        check("reset_fd", {63'd0, fd0}, 64'd0);
        check("reset_err", {63'd0, err0}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("first_an", {56'd0, an0}, 64'hFE);

        for (int k = 0; k < 6; k++) begin
            full_frame($sformatf("vec%0d", k), vt[k].d, 1'b1);
            check_scan($sformatf("vec%0d", k), vt[k].e1, vt[k].e0);
            check($sformatf("vec%0d_onehot", k), 64'($countones(~an0)), 64'd1);
        end

        send_range(32'h99999999, 0, 3);
        drive(2'b10, 4'd4, 4'd9);
        finish_frame("ready_abort", 1'b0);
        check_scan("ready_abort", vt[5].e1, vt[5].e0);

        send_range(32'h55555555, 0, 1);
        drive(2'b01, 4'd3, 4'd5);
        send_range(32'h55555555, 4, 7);
        finish_frame("skip_abort", 1'b0);
        check_scan("skip_abort", vt[5].e1, vt[5].e0);

        send_range(32'h44444444, 0, 4);
        full_frame("restart", vt[0].d, 1'b1);
        check_scan("restart", vt[0].e1, vt[0].e0);

        send_range(vt[3].d, 0, 3);
        drive(2'b01, 4'd9, 4'd1);
        drive(2'b01, 4'd12, 4'd1);
        send_range(vt[3].d, 4, 7);
        finish_frame("pos_hold", 1'b1);
        check_scan("pos_hold", vt[3].e1, vt[3].e0);

        send_range(32'h11111111, 0, 6);
        drive(2'b00, 4'd7, 4'd1);
        finish_frame("err_vs_commit", 1'b0);
        check("err_set0", {63'd0, err0}, 64'd1);
        check("err_set1", {63'd0, err1}, 64'd1);
        full_frame("err_frame_a", vt[4].d, 1'b0);
        full_frame("err_frame_b", vt[1].d, 1'b0);
        check("err_sticky", {63'd0, err0}, 64'd1);
        check_scan("err_screen", ERR_SCR, ERR_SCR);

        @(negedge clock);
        reset = 1'b1;
        #1;
        check("err_reset_err", {63'd0, err0}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        check_scan("post_err", ZERO1, ZERO0);

        full_frame("pre_rst", vt[3].d, 1'b1);
        n = 0;
        while (an0 !== 8'hDF && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("slot5_found", {63'd0, an0 === 8'hDF}, 64'd1);
        drive(2'b01, 4'd0, 4'd3);
        drive(2'b01, 4'd1, 4'd3);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_an", {56'd0, an0}, 64'hFF);
        check("midrst_seg", {56'd0, seg0}, 64'hFF);
        check("midrst_fd", {63'd0, fd0}, 64'd0);
        status = 2'b10;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (an0 === 8'hFF && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("midrst_restart_an", {56'd0, an0}, 64'hFE);
        send_range(32'h33333333, 2, 7);
        finish_frame("midrst_partial", 1'b0);
        check_scan("midrst_disp", ZERO1, ZERO0);

        repeat (4) @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
